// File: rtl/chase_tp_syndrome_gen.sv
// Chase test-pattern syndrome generator: expands the odd-power flip
// contributions of NFLIP weak positions into full syndrome sets and streams
// every flip combination in Gray-code order, one XOR update per beat.
//
// state  | meaning
// IDLE   | waiting for a codeword syndrome set, o_ready high
// EXPAND | one cycle: build contribution table by GF squaring, load running R
// EMIT   | stream R for each Gray-code mask, advance on downstream ready
module chase_tp_syndrome_gen #(
   parameter int M         = 10,
   parameter int T         = 4,
   parameter int NFLIP     = 3,
   parameter int EMIT_ZERO = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [1:0]            i_code,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2*T*M-1:0]      i_syn,
   input  logic [NFLIP*T*M-1:0]  i_alpha_odd,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [2*T*M-1:0]      o_tp_syn,
   output logic [NFLIP-1:0]      o_tp_mask,
   output logic                  o_last
);

   localparam int NSYN = 2 * T;

   // Primitive field polynomial per symbol width (supported M = 3..16).
   function automatic logic [16:0] prim_poly(input int m);
      case (m)
         3:       return 17'h0000b;
         4:       return 17'h00013;
         5:       return 17'h00025;
         6:       return 17'h00043;
         7:       return 17'h00089;
         8:       return 17'h0011d;
         9:       return 17'h00211;
         10:      return 17'h00409;
         11:      return 17'h00805;
         12:      return 17'h01053;
         13:      return 17'h0201b;
         14:      return 17'h04443;
         15:      return 17'h08003;
         16:      return 17'h1100b;
         default: return 17'h00003;
      endcase
   endfunction

   localparam logic [16:0]  POLY_FULL = prim_poly(M);
   localparam logic [M-1:0] POLY      = POLY_FULL[M-1:0];

   // a*a in GF(2^M), shift-and-add with reduction folded into each shift.
   function automatic logic [M-1:0] gf_square(input logic [M-1:0] a);
      logic [M-1:0] p;
      p = '0;
      for (int i = M - 1; i >= 0; i--) begin
         p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0);
         if (a[i]) p = p ^ a;
      end
      return p;
   endfunction

   typedef logic [NSYN-1:0][M-1:0]             synvec_t;
   typedef logic [NFLIP-1:0][NSYN-1:0][M-1:0]  ctab_t;

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_EMIT} state_t;

   state_t                 state_q, state_d;
   logic                   short_q, short_d;
   synvec_t                r_q, r_d;
   logic [NFLIP*T*M-1:0]   alpha_q, alpha_d;
   ctab_t                  c_q, c_d;
   logic [NFLIP-1:0]       k_q, k_d;

   ctab_t                  c_exp;
   synvec_t                syn_masked;
   synvec_t                c_sel;
   logic [NFLIP-1:0]       k_inc;
   logic [NFLIP-1:0]       k_low;
   logic                   last;

   // Contribution table: odd powers straight from input, even powers squared.
   // Entries above S4 on a short code are zeroed; they never feed S1..S4.
   always_comb begin
      c_exp = '0;
      for (int p = 0; p < NFLIP; p++) begin
         for (int j = 0; j < NSYN; j++) begin
            if (j % 2 == 0)
               c_exp[p][j] = alpha_q[(p*T + j/2)*M +: M];
            else
               c_exp[p][j] = gf_square(c_exp[p][(j+1)/2 - 1]);
            if (short_q && j >= 4)
               c_exp[p][j] = '0;
         end
      end
   end

   // Short-code syndrome masking and lowest-set-bit select of the next flip.
   always_comb begin
      syn_masked = r_q;
      if (short_q) begin
         for (int j = 4; j < NSYN; j++)
            syn_masked[j] = '0;
      end
      k_inc = k_q + NFLIP'(1);
      k_low = k_inc & (~k_inc + NFLIP'(1));
      c_sel = '0;
      for (int p = 0; p < NFLIP; p++) begin
         if (k_low[p]) c_sel = c_sel ^ c_q[p];
      end
   end

   assign last = (state_q == S_EMIT) && (k_q == '1);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      short_d = short_q;
      r_d     = r_q;
      alpha_d = alpha_q;
      c_d     = c_q;
      k_d     = k_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid && !i_flush) begin
               r_d     = i_syn;
               alpha_d = i_alpha_odd;
               short_d = (i_code != 2'b10);
               state_d = S_EXPAND;
            end
         end
         S_EXPAND: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else begin
               c_d = c_exp;
               r_d = syn_masked;
               k_d = '0;
               if (EMIT_ZERO == 0) begin
                  r_d = syn_masked ^ c_exp[0];
                  k_d = NFLIP'(1);
               end
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else if (i_ready) begin
               if (last) begin
                  state_d = S_IDLE;
               end else begin
                  k_d = k_inc;
                  r_d = r_q ^ c_sel;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset clears everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         short_q <= 1'b0;
         r_q     <= '0;
         alpha_q <= '0;
         c_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         short_q <= short_d;
         r_q     <= r_d;
         alpha_q <= alpha_d;
         c_q     <= c_d;
         k_q     <= k_d;
      end
   end

   assign o_ready   = (state_q == S_IDLE);
   assign o_valid   = (state_q == S_EMIT);
   assign o_last    = last;
   assign o_tp_syn  = r_q;
   assign o_tp_mask = k_q ^ (k_q >> 1);

endmodule

// File: doc/chase_tp_syndrome_gen.md
Name: chase_tp_syndrome_gen

Overview:
- Parametrised successor of the fixed two-position flip-syndrome stage in the BCH Chase soft-decoder path.
- Accepts one codeword's hard-decision syndromes plus the odd-power alpha contributions of NFLIP least-reliable bit positions.
- Derives the even-power contributions by GF squaring.
- Streams every test-pattern syndrome set, one per accepted beat, in Gray-code order through a valid/ready handshake to the downstream key-equation solver.

Parameters:
- M, 10, GF symbol width in bits.
- T, 4, maximum correctable errors; NSYN = 2*T syndromes; T >= 2.
- NFLIP, 3, number of flip positions; range 1..6; 2^NFLIP patterns.
- EMIT_ZERO, 1, 1 = also emit the unflipped pattern (mask 0) first.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_code  in  2  code select, latched on accept; 2'b10 = all NSYN syndromes active, else S1..S4 only.
- i_valid  in  1  input set valid.
- o_ready  out  1  high only in IDLE.
- i_syn  in  NSYN*M  syndromes; S1 in bits [M-1:0], Sk in bits [k*M-1:(k-1)*M].
- i_alpha_odd  in  NFLIP*T*M  per position p, odd contribution S(2j+1) at offset (p*T+j)*M.
- i_flush  in  1  abort the current set.
- o_valid  out  1  test-pattern syndromes valid.
- i_ready  in  1  downstream accepts.
- o_tp_syn  out  NSYN*M  test-pattern syndromes, same packing as i_syn.
- o_tp_mask  out  NFLIP  flipped-position bitmask (bit p = position p flipped).
- o_last  out  1  final pattern of the set.

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - State -> IDLE.
  - o_valid = 0, o_last = 0, o_tp_syn = 0, o_tp_mask = 0, o_ready = 1 after the edge.
  - All internal tables are cleared.
  - Reset mid-operation discards the set entirely.
- FSM states: IDLE, EXPAND, EMIT.
- IDLE:
  - Accept when i_valid && o_ready && !i_flush.
  - Latch i_syn, i_alpha_odd and i_code; go to EXPAND.
- EXPAND (1 cycle):
  - Build the contribution table C[p][k], k = 1..NSYN.
  - Odd k: taken directly from the input. Even k: C[p][k] = square(C[p][k/2]), using the existing gf_square under the latched code; the squaring chain is combinational within this cycle.
  - When the latched code != 2'b10, entries with k > 4 are forced to 0, and latched syndromes S5..S(NSYN) are also forced to 0.
  - Load the running register R = latched syndromes, pattern counter k = 0.
  - With EMIT_ZERO = 0, additionally pre-XOR C[0][*] into R and set k = 1.
  - Go to EMIT.
- EMIT:
  - Outputs: o_valid = 1, o_tp_syn = R, o_tp_mask = k ^ (k >> 1).
  - o_last = 1 when k = 2^NFLIP - 1.
  - On o_valid && i_ready && !o_last: k <= k + 1; R <= R ^ C[ctz(k+1)][*] (ctz = count of trailing zeros).
  - On o_valid && i_ready && o_last: go to IDLE; o_valid drops on the next cycle.
  - While i_ready = 0, all outputs hold stable.
- Latency and throughput:
  - First o_valid is 2 cycles after the accept edge.
  - Throughput is one pattern per cycle with no bubbles.
  - Beats per set: 2^NFLIP with EMIT_ZERO = 1, 2^NFLIP - 1 with EMIT_ZERO = 0.
- i_flush: in EXPAND or EMIT -> IDLE at the next edge; o_valid = 0, o_last = 0, o_ready = 1. In IDLE, flush blocks the accept.
- Arithmetic:
  - All additions are bitwise XOR, M bits wide, no carries.
  - k is NFLIP bits wide and never wraps, since the set terminates at o_last.
- Each input is consumed once; inputs changing after accept have no effect.

Test Plan:
1. Zero-flip baseline:
   - Setup: M=10, T=4, NFLIP=2, EMIT_ZERO=1, code 2'b10, i_syn = 0, pos0 odd = {S1=2, S3=8, S5=0, S7=0}, pos1 odd = {1, 1, 1, 1}, i_ready = 1.
   - Beat 0: mask 00, all syndromes 0.
   - Beat 1: mask 01, S1..S8 = {2, 4, 8, 16, 0, 64, 0, 256}.
   - Beat 2: mask 11, {3, 5, 9, 17, 1, 65, 1, 257}.
   - Beat 3: mask 10, all 1, o_last = 1.
   - Timing: first o_valid 2 cycles after accept; o_ready low throughout.
2. Backpressure: same stimulus with i_ready = 0 for 3 cycles at beat 2 -> mask 11 and values held unchanged; beat 3 follows the cycle after i_ready returns high; total 4 beats, no skips or duplicates.
3. Short code: same stimulus with i_code = 2'b00 -> S5..S8 outputs = 0 on every beat; S1..S4 match scenario 1.
4. Flush: i_flush pulsed during beat 1 -> o_valid = 0 and o_ready = 1 on the next cycle; a new accept the cycle after restarts from beat 0.
5. Reset mid-EMIT: i_rst = 1 for one edge during beat 2 -> all outputs 0, o_ready = 1; o_valid stays low until a fresh accept.
6. EMIT_ZERO=0, NFLIP=2, scenario-1 stimulus -> exactly 3 beats with masks 01, 11, 10 and values as in scenario 1; o_last on mask 10.
